// File: rtl/stereo_stft_framer_pkg.sv
// Shared FSM encoding and derived-width helper for the stereo STFT framer.
package stereo_stft_framer_pkg;

    localparam logic [1:0] ST_PRIME  = 2'd0;
    localparam logic [1:0] ST_EMIT   = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // Counters must reach FFT_SIZE itself, so they need one bit more than a pointer.
    function automatic int framer_cnt_w(input int fft_size);
        return $clog2(fft_size) + 1;
    endfunction

endpackage

// File: rtl/stereo_stft_framer_ram.sv
// Simple dual-port sample store: one write port, one read port with a registered read.
module stereo_stft_framer_ram #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stereo_stft_framer.sv
// Stereo PCM to overlapping STFT frames (FFT_SIZE long, HOP_SIZE advance), each ended by tlast.
// Optional end-of-stream zero padding is built when STFT_FRAMER_FLUSH_EN is defined.
module stereo_stft_framer
    import stereo_stft_framer_pkg::*;
#(
    parameter int FFT_SIZE     = 4096,
    parameter int HOP_SIZE     = 1024,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [2*SAMPLE_WIDTH-1:0]     s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [2*SAMPLE_WIDTH-1:0]     m_axis_tdata,
    output logic [2*SAMPLE_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [1:0]                    dbg_state
);

    localparam int DW    = 2 * SAMPLE_WIDTH;
    localparam int KW    = DW / 8;
    localparam int PTR_W = $clog2(FFT_SIZE);
    localparam int CNT_W = framer_cnt_w(FFT_SIZE);
    localparam logic [CNT_W-1:0] FFT_CNT = CNT_W'(FFT_SIZE);
    localparam logic [CNT_W-1:0] HOP_CNT = CNT_W'(HOP_SIZE);

    // Both ports: a beat transfers on a cycle where valid and ready are high together;
    // valid never waits on ready, and a stalled output beat holds data/last unchanged.

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, rd_cnt_q, target;
    logic             s_ready_q, full_tgt_q, eos_q, eos_in, zero_fill;
    logic             s_fire, wr_en, fill_done, rd_issue, rd_last, m_fire, frame_done;
    logic [DW-1:0]    wr_data, rd_data;
    logic             rd_valid_q, rd_last_q;
    logic             head_valid_q, head_last_q, skid_valid_q, skid_last_q;
    logic [DW-1:0]    head_data_q, skid_data_q;

    assign s_fire     = s_axis_tvalid && s_ready_q;
    assign target     = full_tgt_q ? FFT_CNT : HOP_CNT;
    assign wr_en      = s_fire || zero_fill;
    assign wr_data    = zero_fill ? '0 : s_axis_tdata;
    assign fill_done  = wr_en && ((cnt_q + 1'b1) == target);
    assign m_fire     = head_valid_q && m_axis_tready;
    assign frame_done = m_fire && head_last_q;
    // At most two beats may be buffered or in flight; a pop this cycle frees one slot.
    assign rd_issue   = (state_q == ST_EMIT) && (rd_cnt_q != FFT_CNT) &&
                        (!(head_valid_q && (skid_valid_q || rd_valid_q)) || m_fire);
    assign rd_last    = (rd_cnt_q == FFT_CNT - 1'b1);

`ifdef STFT_FRAMER_FLUSH_EN
    assign zero_fill = (state_q == ST_FLUSH);
    assign eos_in    = s_fire && s_axis_tlast;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         eos_q <= 1'b0;
        else if (eos_in)     eos_q <= 1'b1;
        else if (frame_done) eos_q <= 1'b0;
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign zero_fill    = 1'b0;
    assign eos_in       = 1'b0;
    assign eos_q        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMIT: if (frame_done) state_d = eos_q ? ST_PRIME : ST_REFILL;
            default: begin
                if (fill_done)   state_d = ST_EMIT;
                else if (eos_in) state_d = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_PRIME;
            s_ready_q  <= 1'b0;
            full_tgt_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= (state_d == ST_PRIME) || (state_d == ST_REFILL);
            rd_valid_q <= rd_issue;
            rd_last_q  <= rd_issue && rd_last;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                cnt_q    <= cnt_q + 1'b1;
            end
            // The oldest sample sits where the next write would land.
            if (fill_done) begin
                rd_ptr_q <= wr_ptr_q + 1'b1;
                rd_cnt_q <= '0;
            end
            if (rd_issue) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (frame_done) begin
                cnt_q      <= '0;
                full_tgt_q <= eos_q;
            end
        end
    end

    stereo_stft_framer_ram #(
        .DEPTH (FFT_SIZE),
        .WIDTH (DW),
        .AW    (PTR_W)
    ) u_framer_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_issue),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Two-entry skid: head drives the port, skid catches a read landing during a stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_valid_q <= 1'b0;
            head_last_q  <= 1'b0;
            head_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
        end else if (m_fire) begin
            if (skid_valid_q) begin
                head_data_q  <= skid_data_q;
                head_last_q  <= skid_last_q;
                skid_valid_q <= 1'b0;
            end else if (rd_valid_q) begin
                head_data_q <= rd_data;
                head_last_q <= rd_last_q;
            end else begin
                head_valid_q <= 1'b0;
                head_last_q  <= 1'b0;
            end
        end else if (rd_valid_q) begin
            if (!head_valid_q) begin
                head_valid_q <= 1'b1;
                head_data_q  <= rd_data;
                head_last_q  <= rd_last_q;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= rd_data;
                skid_last_q  <= rd_last_q;
            end
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tdata  = head_data_q;
    assign m_axis_tlast  = head_last_q;
    assign m_axis_tvalid = head_valid_q;
    assign m_axis_tkeep  = {KW{head_valid_q}};
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_stereo_stft_framer.sv
// Randomized bench for stereo_stft_framer: ramp stimulus, frame-level reference queue.
module tb_stereo_stft_framer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;

    logic        a_s_tvalid, a_m_tready, b_s_tvalid, b_m_tready;
    logic        a_s_tready, a_m_tlast, a_m_tvalid, b_s_tready, b_m_tlast, b_m_tvalid;
    logic [31:0] a_m_tdata, b_m_tdata;
    logic [3:0]  a_m_tkeep, b_m_tkeep;
    logic [1:0]  unused_dbg_a, unused_dbg_b;

    logic        s_tready, m_tlast, m_tvalid;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;

    int          total = 0, bad = 0;
    int          n = 0, limit = 0, tlast_at = -1, beats = 0;
    bit          run = 0, sink = 0, src_gap = 0, snk_gap = 0;
    logic        src_fire;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    assign a_s_tvalid = s_tvalid && !sel;
    assign b_s_tvalid = s_tvalid && sel;
    assign a_m_tready = m_tready && !sel;
    assign b_m_tready = m_tready && sel;
    assign s_tready   = sel ? b_s_tready : a_s_tready;
    assign m_tdata    = sel ? b_m_tdata  : a_m_tdata;
    assign m_tlast    = sel ? b_m_tlast  : a_m_tlast;
    assign m_tvalid   = sel ? b_m_tvalid : a_m_tvalid;
    assign m_tkeep    = sel ? b_m_tkeep  : a_m_tkeep;

    stereo_stft_framer #(.FFT_SIZE(16), .HOP_SIZE(4), .SAMPLE_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tlast(a_m_tlast),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready), .dbg_state(unused_dbg_a)
    );

    stereo_stft_framer #(.FFT_SIZE(16), .HOP_SIZE(16), .SAMPLE_WIDTH(16)) dut_b (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .dbg_state(unused_dbg_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ramp(input int idx);
        logic [15:0] l, r;
        l = 16'(idx);
        r = 16'(1000 + idx);
        return {l, r};
    endfunction

    // Frame k of a stream holds samples base+k*hop ... base+k*hop+15.
    task automatic push_frames(input int hop, input int base, input int nfr);
        for (int k = 0; k < nfr; k++)
            for (int i = 0; i < 16; i++)
                exp_q.push_back({(i == 15), ramp(base + k * hop + i)});
    endtask

    task automatic do_reset();
        run = 0;
        sink = 0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b0;
        n = 0;
        beats = 0;
        exp_q.delete();
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tlast"},  m_tlast, 0);
        check({tag, "_m_tdata"},  m_tdata, 0);
        check({tag, "_m_tkeep"},  m_tkeep, 0);
    endtask

    // Source driver: ramp sample n, advanced after each accepted handshake.
    initial begin
        forever begin
            @(negedge clk);
            src_fire = s_tvalid && s_tready && resetn;
            @(posedge clk);
            #1;
            if (src_fire) n++;
            s_tvalid = run && (n < limit) && (!src_gap || $urandom_range(0, 1) == 1);
            s_tdata  = ramp(n);
            s_tlast  = (n == tlast_at);
        end
    end

    // Sink and scoreboard: accept only expected beats, check stalls hold steady.
    initial begin : sink_proc
        bit          stall = 0, rise = 0;
        logic [32:0] held = '0, exp_v;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall = 0;
                rise  = 0;
            end else begin
                if (stall) begin
                    check("hold_valid", m_tvalid, 1);
                    check("hold_data", {m_tlast, m_tdata}, held);
                end
                if (m_tvalid && m_tready) begin
                    beats++;
                    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : ~{m_tlast, m_tdata};
                    check("beat", {m_tlast, m_tdata}, exp_v);
                    check("tkeep", m_tkeep, 4'hf);
                    if (m_tlast) rise = 1;
                end
                stall = m_tvalid && !m_tready;
                held  = {m_tlast, m_tdata};
            end
            @(posedge clk);
            #1;
            if (rise && resetn) check("tready_rise", s_tready, 1);
            rise = 0;
            m_tready = sink && (exp_q.size() != 0) && (!snk_gap || $urandom_range(0, 1) == 1);
        end
    end

    initial begin
        int k;
        limit = 1000;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        resetn = 1'b1;
        @(posedge clk);
        #2;
        check("tready_after_rst", s_tready, 1);

        // Continuous ramp, sink always ready; also probe handshake-to-output latency.
        do_reset();
        push_frames(4, 0, 3);
        run = 1;
        sink = 1;
        k = 0;
        while (n < 16 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("prime_samples", n, 16);
        check("tready_drop", s_tready, 0);
        check("lat_cycle0", m_tvalid, 0);
        @(posedge clk);
        #2;
        check("lat_cycle1", m_tvalid, 0);
        @(posedge clk);
        #2;
        check("lat_cycle2", m_tvalid, 1);
        wait_drain("drain_cont", 2000);

        // Random gaps on both sides: same beat sequence.
        do_reset();
        src_gap = 1;
        snk_gap = 1;
        push_frames(4, 0, 3);
        run = 1;
        sink = 1;
        wait_drain("drain_gaps", 4000);
        src_gap = 0;
        snk_gap = 0;

        // Reset in the middle of frame 1, then the buffer refills from scratch.
        do_reset();
        push_frames(4, 0, 3);
        run = 1;
        sink = 1;
        k = 0;
        while (beats < 23 && k < 2000) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("beats_before_rst", beats, 23);
        resetn = 1'b0;
        run = 0;
        #1;
        check_reset_outputs("mid_rst");
        n = 0;
        beats = 0;
        exp_q.delete();
        @(posedge clk);
        #2;
        resetn = 1'b1;
        push_frames(4, 0, 1);
        run = 1;
        wait_drain("drain_post_rst", 2000);

        // tlast on sample 9 while priming.
        do_reset();
        limit = 26;
        tlast_at = 9;
`ifdef STFT_FRAMER_FLUSH_EN
        for (int i = 0; i < 16; i++)
            exp_q.push_back({(i == 15), (i < 10) ? ramp(i) : 32'h0});
        push_frames(4, 10, 1);
`else
        push_frames(4, 0, 3);
`endif
        run = 1;
        sink = 1;
        wait_drain("drain_tlast", 2000);
        tlast_at = -1;

        // Non-overlapping frames on the HOP_SIZE==FFT_SIZE instance.
        do_reset();
        sel = 1'b1;
        limit = 32;
        push_frames(16, 0, 2);
        run = 1;
        sink = 1;
        wait_drain("drain_hop16", 2000);
        repeat (40) @(posedge clk);
        #2;
        check("hop16_no_extra", m_tvalid, 0);
        check("hop16_samples", n, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
